// File: rtl/seq_divider.sv
// Sequential repeated-subtraction divider with start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands (sign-magnitude wrap around the core).
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start
    // CHECK | divisor zero test
    // SUB   | one subtraction per cycle while r >= d
    // DONE  | results loaded, done pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_SUB   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] load_d;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign load_r = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign load_d = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    assign q_res  = neg_q ? (~q + ONE) : q;
    assign r_res  = neg_r ? (~r + ONE) : r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign load_r = dividend;
    assign load_d = divisor;
    assign q_res  = q;
    assign r_res  = r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CHECK;
            S_CHECK: state_nxt = (d == '0) ? S_DONE : S_SUB;
            S_SUB:   if (r < d) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_CHECK, S_SUB: busy = 1'b1;
            S_DONE:         done = 1'b1;
            default:        ;
        endcase
    end

    // Result registers only load on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            d           <= '0;
            q           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r           <= load_r;
                        d           <= load_d;
                        q           <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (d == '0) begin
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= r_res;
                    end
                end
                S_SUB: begin
                    if (r >= d) begin
                        r <= r - d;
                        q <= q + ONE;
                    end else begin
                        quotient  <= q_res;
                        remainder <= r_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, monitor checks on each done pulse.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   bcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: plain integer division on magnitudes, signs reapplied afterwards.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        int   ua, ub, qm, rm;
        bit   na, nb;
`ifdef SEQ_DIVIDER_SIGNED_EN
        na = a[W-1];
        nb = b[W-1];
        ua = na ? (1 << W) - int'(a) : int'(a);
        ub = nb ? (1 << W) - int'(b) : int'(b);
`else
        na = 1'b0;
        nb = 1'b0;
        ua = int'(a);
        ub = int'(b);
`endif
        m.cyc = 0;
        if (ub == 0) begin
            m.q   = '1;
            m.r   = a;
            m.dbz = 1'b1;
            m.lat = 1;
        end else begin
            qm    = ua / ub;
            rm    = ua % ub;
            m.q   = W'((na ^ nb) ? -qm : qm);
            m.r   = W'(na ? -rm : rm);
            m.dbz = 1'b0;
            m.lat = qm + 2;
        end
        return m;
    endfunction

    // Monitor: sampled on the falling edge, so cyc equals the number of rising edges so far.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (done) begin
                exp_t e;
                chk("busy_with_done", busy, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", bcnt, e.lat);
                end
                bcnt = 0;
            end
        end
    end

    // Issues one operation from IDLE; while busy, random start pulses must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noisy);
        exp_t e;
        bit   seen = 0;
        @(negedge clk);
        e = model(a, b);
        e.cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        start = 1'b1;
        dividend = a;
        divisor = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            dividend = W'($urandom);
            divisor = W'($urandom);
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        exp_t e;
        bit   back_ok;
        #1;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_op(8'hF9, 8'd2, 0);
        do_op(8'd7, 8'hFE, 0);
        do_op(8'h80, 8'hFF, 0);
        do_op(8'h80, 8'h01, 0);
`endif
        do_op(8'd100, 8'd7, 0);
        do_op(8'd5, 8'd9, 1);
        do_op(8'd255, 8'd1, 1);
        do_op(8'd37, 8'd0, 0);
        repeat (3) @(negedge clk);
        chk("dbz_held", div_by_zero, 1);
        chk("quotient_held", quotient, 8'hFF);
        do_op(8'd20, 8'd4, 0);
        do_op(8'd0, 8'd13, 0);

        // Abort mid-operation: no push, so any done would be flagged as unexpected.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(8'd9, 8'd3, 0);

        // Start held high: accepts at E, E+7, E+14; dropped before E+21.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            e = model(8'd12, 8'd4);
            e.cyc = cyc + 1 + 7 * k + e.lat;
            sb.push_back(e);
        end
        start = 1'b1;
        dividend = 8'd12;
        divisor = 8'd4;
        repeat (15) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        back_ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                back_ok = 1;
                break;
            end
        end
        chk("back_to_back_drained", back_ok, 1);
        repeat (10) @(negedge clk);

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            do_op(a, b, ($urandom_range(0, 1) == 1));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
